// File: rtl/servo_pwm_rampa.sv
`default_nettype none
//==============================================================================
// servo_pwm_rampa
//   Multi-channel servo PWM whose positions slew toward their targets by one
//   step every RAMPA_PERIODOS periods; pulse width = LARGURA_MIN + pos*PASSO.
// Rev 1.0 - initial release
//==============================================================================
module servo_pwm_rampa #(
    parameter int CANAIS         = 2,
    parameter int LARGURA_POS    = 5,
    parameter int CONF_PERIODO   = 1000000,
    parameter int LARGURA_MIN    = 50000,
    parameter int PASSO          = 1000,
    parameter int POS_MAX        = 28,
    parameter int POS_INICIAL    = 14,
    parameter int RAMPA_PERIODOS = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CANAIS-1:0]             habilita,
    input  logic [CANAIS*LARGURA_POS-1:0] posicao,
    output logic [CANAIS-1:0]             pwm,
    output logic [CANAIS*LARGURA_POS-1:0] pos_atual,
    output logic [CANAIS-1:0]             movendo,
    output logic                          fim_periodo
);

    localparam int CW = (CONF_PERIODO > 1) ? $clog2(CONF_PERIODO) : 1;
    localparam int RW = (RAMPA_PERIODOS > 1) ? $clog2(RAMPA_PERIODOS) : 1;

    localparam logic [CW-1:0]          CONTA_ULT     = CW'(CONF_PERIODO - 1);
    localparam logic [RW-1:0]          RAMPA_ULT     = RW'(RAMPA_PERIODOS - 1);
    localparam logic [LARGURA_POS-1:0] POS_TETO      = LARGURA_POS'(POS_MAX);
    localparam logic [LARGURA_POS-1:0] POS_RESET     = LARGURA_POS'(POS_INICIAL);
    localparam logic [31:0]            LARGURA_RESET = 32'(LARGURA_MIN + POS_INICIAL * PASSO);

    logic [CW-1:0]     contagem;
    logic [RW-1:0]     rampa_cnt;
    logic [CANAIS-1:0] hab_ativo;
    logic              wrap;
    logic              passo_agora;

    assign wrap        = (contagem == CONTA_ULT);
    assign passo_agora = (rampa_cnt == RAMPA_ULT);

    // Shared period and ramp counters keep every channel phase-aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem    <= '0;
            rampa_cnt   <= '0;
            hab_ativo   <= '0;
            fim_periodo <= 1'b0;
        end else begin
            fim_periodo <= wrap;
            if (wrap) begin
                contagem  <= '0;
                hab_ativo <= habilita;
                rampa_cnt <= passo_agora ? '0 : rampa_cnt + RW'(1);
            end else begin
                contagem <= contagem + CW'(1);
            end
        end
    end

    for (genvar i = 0; i < CANAIS; i++) begin : g_canal
        logic [LARGURA_POS-1:0] pedido;
        logic [LARGURA_POS-1:0] alvo;
        logic [LARGURA_POS-1:0] atual;
        logic [LARGURA_POS-1:0] prox;
        logic [31:0]            largura_ativa;
        logic [31:0]            largura_prox;
        logic                   pwm_q;
        logic                   movendo_q;

        assign pedido = posicao[i*LARGURA_POS +: LARGURA_POS];

        // The step decision uses hab_ativo from before this wrap, so a channel
        // disabled for the ending period holds its position.
        always_comb begin
            alvo = (pedido > POS_TETO) ? POS_TETO : pedido;
            prox = atual;
            if (passo_agora && hab_ativo[i]) begin
                if (atual < alvo) begin
                    prox = atual + LARGURA_POS'(1);
                end else if (atual > alvo) begin
                    prox = atual - LARGURA_POS'(1);
                end
            end
            largura_prox = 32'(LARGURA_MIN) + 32'(prox) * 32'(PASSO);
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                atual         <= POS_RESET;
                largura_ativa <= LARGURA_RESET;
                pwm_q         <= 1'b0;
                movendo_q     <= 1'b0;
            end else begin
                pwm_q <= hab_ativo[i] && (32'(contagem) < largura_ativa);
                // Width loads only at the boundary so no pulse is ever cut.
                if (wrap) begin
                    atual         <= prox;
                    largura_ativa <= largura_prox;
                    movendo_q     <= (prox != alvo);
                end
            end
        end

        assign pwm[i]                                  = pwm_q;
        assign movendo[i]                              = movendo_q;
        assign pos_atual[i*LARGURA_POS +: LARGURA_POS] = atual;
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_rampa.sv
`default_nettype none
//==============================================================================
// tb_servo_pwm_rampa
//   Directed bench: period-by-period widths, ramp, clamp, enable, reset, edges.
// Rev 1.0 - initial release
//==============================================================================
module tb_servo_pwm_rampa;

    logic       clock;
    logic       reset;
    logic [1:0] habilita;
    logic [5:0] posicao;
    logic [1:0] pwm;
    logic [5:0] pos_atual;
    logic [1:0] movendo;
    logic       fim_periodo;

    logic [1:0] hab6;
    logic [5:0] pos6;
    logic [1:0] pwm_alto, pwm_baixo, mov_alto, mov_baixo;
    logic [5:0] pa_alto, pa_baixo;
    logic       fim_alto, fim_baixo;

    int total = 0;
    int bad   = 0;

    servo_pwm_rampa #(
        .CANAIS(2), .LARGURA_POS(3), .CONF_PERIODO(20), .LARGURA_MIN(4), .PASSO(2),
        .POS_MAX(5), .POS_INICIAL(0), .RAMPA_PERIODOS(2)
    ) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .posicao(posicao),
        .pwm(pwm), .pos_atual(pos_atual), .movendo(movendo), .fim_periodo(fim_periodo)
    );

    servo_pwm_rampa #(
        .CANAIS(2), .LARGURA_POS(3), .CONF_PERIODO(20), .LARGURA_MIN(20), .PASSO(0),
        .POS_MAX(5), .POS_INICIAL(0), .RAMPA_PERIODOS(2)
    ) dut_alto (
        .clock(clock), .reset(reset), .habilita(hab6), .posicao(pos6),
        .pwm(pwm_alto), .pos_atual(pa_alto), .movendo(mov_alto), .fim_periodo(fim_alto)
    );

    servo_pwm_rampa #(
        .CANAIS(2), .LARGURA_POS(3), .CONF_PERIODO(20), .LARGURA_MIN(0), .PASSO(2),
        .POS_MAX(5), .POS_INICIAL(0), .RAMPA_PERIODOS(2)
    ) dut_baixo (
        .clock(clock), .reset(reset), .habilita(hab6), .posicao(pos6),
        .pwm(pwm_baixo), .pos_atual(pa_baixo), .movendo(mov_baixo), .fim_periodo(fim_baixo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Ticks until fim_periodo rises (bounded), counting pwm highs on both channels.
    task automatic esperar_fim(input string tag, output int esperou, output int altos);
        esperou = 0;
        altos   = 0;
        do begin
            tick();
            esperou++;
            altos += int'(pwm[0]) + int'(pwm[1]);
        end while (!fim_periodo && esperou < 40);
        verifica({tag, ".fim_visto"}, 32'(fim_periodo), 1);
    endtask

    // Measures one period starting at the current (or next) fim_periodo pulse.
    task automatic periodo(input string tag, input int acao, input logic [1:0] hab_acao,
                           input int ew0, input int ew1, input int ep0, input int ep1,
                           input int emov);
        int esp, w0, w1, nfim, sub1, p0, p1, mv;
        esp = 0;
        while (!fim_periodo && esp < 40) begin
            tick();
            esp++;
        end
        verifica({tag, ".fim"}, 32'(fim_periodo), 1);
        p0 = int'(pos_atual[2:0]);
        p1 = int'(pos_atual[5:3]);
        mv = int'(movendo);
        w0 = 0; w1 = 0; nfim = 0; sub1 = 0;
        for (int t = 1; t <= 20; t++) begin
            if (t == acao) habilita = hab_acao;
            tick();
            w0   += int'(pwm[0]);
            w1   += int'(pwm[1]);
            nfim += int'(fim_periodo);
            if (t == 1) sub1 = int'(pwm[1]);
        end
        verifica({tag, ".w0"}, 32'(w0), 32'(ew0));
        verifica({tag, ".w1"}, 32'(w1), 32'(ew1));
        verifica({tag, ".pos0"}, 32'(p0), 32'(ep0));
        verifica({tag, ".pos1"}, 32'(p1), 32'(ep1));
        verifica({tag, ".mov"}, 32'(mv), 32'(emov));
        verifica({tag, ".nfim"}, 32'(nfim), 1);
        verifica({tag, ".sobe1"}, 32'(sub1), (ew1 > 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int esp, alt, a0, a1, b;
        reset    = 1'b1;
        habilita = 2'b00;
        posicao  = 6'd0;
        hab6     = 2'b11;
        pos6     = 6'd0;
        repeat (3) tick();

        verifica("rst.pwm", 32'(pwm), 0);
        verifica("rst.pos", 32'(pos_atual), 0);
        verifica("rst.mov", 32'(movendo), 0);
        verifica("rst.fim", 32'(fim_periodo), 0);

        // Test 1: first period stays low, fim arrives 20 clocks after reset.
        habilita = 2'b11;
        reset    = 1'b0;
        esperar_fim("t1.pre", esp, alt);
        verifica("t1.espera", 32'(esp), 20);
        verifica("t1.baixo", 32'(alt), 0);

        // Test 2: channel 0 ramps 0 -> 3, one step every two periods.
        posicao = {3'd0, 3'd3};
        periodo("t2.A", 0, 2'b11,  4, 4, 0, 0, 0);
        periodo("t2.B", 0, 2'b11,  6, 4, 1, 0, 1);
        periodo("t2.C", 0, 2'b11,  6, 4, 1, 0, 1);
        periodo("t2.D", 0, 2'b11,  8, 4, 2, 0, 1);
        periodo("t2.E", 0, 2'b11,  8, 4, 2, 0, 1);
        periodo("t2.F", 0, 2'b11, 10, 4, 3, 0, 0);
        periodo("t2.G", 0, 2'b11, 10, 4, 3, 0, 0);

        // Test 3: channel 1 request 7 clamps to 5.
        posicao = {3'd7, 3'd3};
        periodo("t3.H", 0, 2'b11, 10,  4, 3, 0, 0);
        periodo("t3.I", 0, 2'b11, 10,  4, 3, 0, 2);
        periodo("t3.J", 0, 2'b11, 10,  6, 3, 1, 2);
        periodo("t3.K", 0, 2'b11, 10,  6, 3, 1, 2);
        periodo("t3.L", 0, 2'b11, 10,  8, 3, 2, 2);
        periodo("t3.M", 0, 2'b11, 10,  8, 3, 2, 2);
        periodo("t3.N", 0, 2'b11, 10, 10, 3, 3, 2);
        periodo("t3.O", 0, 2'b11, 10, 10, 3, 3, 2);
        periodo("t3.P", 0, 2'b11, 10, 12, 3, 4, 2);
        periodo("t3.Q", 0, 2'b11, 10, 12, 3, 4, 2);
        periodo("t3.R", 0, 2'b11, 10, 14, 3, 5, 0);
        periodo("t3.S", 0, 2'b11, 10, 14, 3, 5, 0);

        // Test 4: reverse ch0 toward 0, drop its enable mid-pulse, re-enable.
        posicao = {3'd7, 3'd0};
        periodo("t4.T", 0,  2'b11, 10, 14, 3, 5, 0);
        periodo("t4.U", 0,  2'b11, 10, 14, 3, 5, 1);
        periodo("t4.V", 4,  2'b10,  8, 14, 2, 5, 1);
        periodo("t4.W", 0,  2'b10,  0, 14, 2, 5, 1);
        periodo("t4.X", 10, 2'b11,  0, 14, 2, 5, 1);
        periodo("t4.Y", 0,  2'b11,  8, 14, 2, 5, 1);
        periodo("t4.Z", 0,  2'b11,  6, 14, 1, 5, 1);

        // Test 5: one-clock reset while ch0 is at 2 with its pulse high.
        posicao = {3'd7, 3'd3};
        esperar_fim("t5.pre", esp, alt);
        verifica("t5.pre_altos", 32'(alt), 20);
        tick();
        tick();
        verifica("t5.pos0_antes", 32'(pos_atual[2:0]), 2);
        verifica("t5.pwm0_antes", 32'(pwm[0]), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        verifica("t5.pwm", 32'(pwm), 0);
        verifica("t5.pos", 32'(pos_atual), 0);
        verifica("t5.mov", 32'(movendo), 0);
        verifica("t5.fim", 32'(fim_periodo), 0);
        verifica("t5.alto_rst", 32'(pwm_alto), 0);
        esperar_fim("t5.pos_rst", esp, alt);
        verifica("t5.espera", 32'(esp), 20);
        verifica("t5.baixo", 32'(alt), 0);
        periodo("t5.A", 0, 2'b11, 4, 4, 0, 0, 3);

        // Test 6: width >= period gives constant high, width 0 constant low.
        a0 = 0; a1 = 0; b = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            a0 += int'(pwm_alto[0]);
            a1 += int'(pwm_alto[1]);
            b  += int'(pwm_baixo[0]) + int'(pwm_baixo[1]);
        end
        verifica("t6.alto0", 32'(a0), 40);
        verifica("t6.alto1", 32'(a1), 40);
        verifica("t6.baixo", 32'(b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
